// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller
//
// Moore-style control FSM for a shared-memory multicycle datapath. Each
// instruction is sequenced over 3-5 cycles, plus one cycle for every cycle
// that mem_ready is low during a memory access.
//
// Optional feature: define MULTICYCLE_CONTROLLER_BNE_EN to decode op 0110 as
// BNE (BRANCH with pcwrite = ~zero). When it is undefined, op 0110 is illegal.
//
// Parameters:
//   OP_W       opcode width (>=4), encodings zero-extended
//   FUNCT_W    funct width (>=4), encodings zero-extended
//   ALUCTRL_W  alucontrol width (>=4)
//
// Ports:
//   clk         system clock, rising edge
//   reset_n     asynchronous active-low reset (state -> FETCH, strobes low)
//   op, funct   instruction fields from the IR
//   zero        ALU zero flag
//   mem_ready   memory access completes this cycle
//   pcwrite, iord, irwrite, memwrite, regdst, memtoreg, regwrite,
//   alusrca, alusrcb, pcsrc, alucontrol   datapath controls
//   illegal_op  one-cycle pulse on an undecodable instruction
//   instr_done  one-cycle pulse in the final cycle of each instruction
//   state       current FSM state (debug)
// ---------------------------------------------------------------------------
module multicycle_controller #(
    parameter int OP_W      = 4,
    parameter int FUNCT_W   = 4,
    parameter int ALUCTRL_W = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [OP_W-1:0]      op,
    input  logic [FUNCT_W-1:0]   funct,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 pcwrite,
    output logic                 iord,
    output logic                 irwrite,
    output logic                 memwrite,
    output logic                 regdst,
    output logic                 memtoreg,
    output logic                 regwrite,
    output logic                 alusrca,
    output logic [1:0]           alusrcb,
    output logic [1:0]           pcsrc,
    output logic [ALUCTRL_W-1:0] alucontrol,
    output logic                 illegal_op,
    output logic                 instr_done,
    output logic [3:0]           state
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11,
        S_ILLEGAL = 4'd12
    } state_t;

    localparam logic [OP_W-1:0] OP_R    = OP_W'(4'b0000);
    localparam logic [OP_W-1:0] OP_LW   = OP_W'(4'b0001);
    localparam logic [OP_W-1:0] OP_SW   = OP_W'(4'b0010);
    localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(4'b0011);
    localparam logic [OP_W-1:0] OP_ADDI = OP_W'(4'b0100);
    localparam logic [OP_W-1:0] OP_J    = OP_W'(4'b0101);
`ifdef MULTICYCLE_CONTROLLER_BNE_EN
    localparam logic [OP_W-1:0] OP_BNE  = OP_W'(4'b0110);
`endif

    localparam logic [FUNCT_W-1:0] FN_ADD = FUNCT_W'(4'b0000);
    localparam logic [FUNCT_W-1:0] FN_SUB = FUNCT_W'(4'b0001);
    localparam logic [FUNCT_W-1:0] FN_AND = FUNCT_W'(4'b0010);
    localparam logic [FUNCT_W-1:0] FN_OR  = FUNCT_W'(4'b0011);
    localparam logic [FUNCT_W-1:0] FN_SLT = FUNCT_W'(4'b0100);

    localparam logic [ALUCTRL_W-1:0] ALU_AND = ALUCTRL_W'(4'b0000);
    localparam logic [ALUCTRL_W-1:0] ALU_OR  = ALUCTRL_W'(4'b0001);
    localparam logic [ALUCTRL_W-1:0] ALU_ADD = ALUCTRL_W'(4'b0010);
    localparam logic [ALUCTRL_W-1:0] ALU_SUB = ALUCTRL_W'(4'b0110);
    localparam logic [ALUCTRL_W-1:0] ALU_SLT = ALUCTRL_W'(4'b0111);

    // True when the R-type funct field is one the ALU supports.
    function automatic logic funct_valid(input logic [FUNCT_W-1:0] f);
        logic ok;
        case (f)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: ok = 1'b1;
            default:                               ok = 1'b0;
        endcase
        return ok;
    endfunction

    // R-type funct to ALU operation; unknown funct falls back to add.
    function automatic logic [ALUCTRL_W-1:0] funct_alu(input logic [FUNCT_W-1:0] f);
        logic [ALUCTRL_W-1:0] a;
        case (f)
            FN_ADD:  a = ALU_ADD;
            FN_SUB:  a = ALU_SUB;
            FN_AND:  a = ALU_AND;
            FN_OR:   a = ALU_OR;
            FN_SLT:  a = ALU_SLT;
            default: a = ALU_ADD;
        endcase
        return a;
    endfunction

    state_t               state_r;
    state_t               state_next_s;
    logic [ALUCTRL_W-1:0] exec_alu_r;

    logic                 pcwrite_s;
    logic                 iord_s;
    logic                 irwrite_s;
    logic                 memwrite_s;
    logic                 regdst_s;
    logic                 memtoreg_s;
    logic                 regwrite_s;
    logic                 alusrca_s;
    logic [1:0]           alusrcb_s;
    logic [1:0]           pcsrc_s;
    logic [ALUCTRL_W-1:0] alucontrol_s;
    logic                 illegal_op_s;
    logic                 instr_done_s;
    logic                 branch_take_s;

`ifdef MULTICYCLE_CONTROLLER_BNE_EN
    logic                 bne_r;

    // Remember whether the branch being executed is BNE (op sampled in DECODE).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bne_r <= 1'b0;
        end else if (state_r == S_DECODE) begin
            bne_r <= (op == OP_BNE);
        end else begin
            bne_r <= bne_r;
        end
    end

    assign branch_take_s = bne_r ? ~zero : zero;
`else
    assign branch_take_s = zero;
`endif

    // State register; reset aborts any instruction in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Capture the R-type ALU operation in DECODE so later funct changes are ignored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exec_alu_r <= ALU_ADD;
        end else if (state_r == S_DECODE) begin
            exec_alu_r <= funct_alu(funct);
        end else begin
            exec_alu_r <= exec_alu_r;
        end
    end

    // Next-state and Moore output decode.
    always_comb begin
        state_next_s = state_r;
        pcwrite_s    = 1'b0;
        iord_s       = 1'b0;
        irwrite_s    = 1'b0;
        memwrite_s   = 1'b0;
        regdst_s     = 1'b0;
        memtoreg_s   = 1'b0;
        regwrite_s   = 1'b0;
        alusrca_s    = 1'b0;
        alusrcb_s    = 2'b00;
        pcsrc_s      = 2'b00;
        alucontrol_s = ALU_ADD;
        illegal_op_s = 1'b0;
        instr_done_s = 1'b0;

        case (state_r)
            S_FETCH: begin
                alusrcb_s = 2'b01;
                irwrite_s = mem_ready;
                pcwrite_s = mem_ready;
                if (mem_ready) begin
                    state_next_s = S_DECODE;
                end else begin
                    state_next_s = S_FETCH;
                end
            end
            S_DECODE: begin
                // Branch target is precomputed into ALUOut here.
                alusrcb_s = 2'b11;
                case (op)
                    OP_R: begin
                        if (funct_valid(funct)) begin
                            state_next_s = S_EXEC;
                        end else begin
                            state_next_s = S_ILLEGAL;
                        end
                    end
                    OP_LW, OP_SW: state_next_s = S_MEMADR;
                    OP_BEQ:       state_next_s = S_BRANCH;
`ifdef MULTICYCLE_CONTROLLER_BNE_EN
                    OP_BNE:       state_next_s = S_BRANCH;
`endif
                    OP_ADDI:      state_next_s = S_ADDIEX;
                    OP_J:         state_next_s = S_JUMP;
                    default:      state_next_s = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                alusrca_s = 1'b1;
                alusrcb_s = 2'b10;
                if (op == OP_SW) begin
                    state_next_s = S_MEMWR;
                end else begin
                    state_next_s = S_MEMRD;
                end
            end
            S_MEMRD: begin
                iord_s = 1'b1;
                if (mem_ready) begin
                    state_next_s = S_MEMWB;
                end else begin
                    state_next_s = S_MEMRD;
                end
            end
            S_MEMWB: begin
                memtoreg_s   = 1'b1;
                regwrite_s   = 1'b1;
                instr_done_s = 1'b1;
                state_next_s = S_FETCH;
            end
            S_MEMWR: begin
                // Write request stays asserted for the whole wait.
                iord_s     = 1'b1;
                memwrite_s = 1'b1;
                if (mem_ready) begin
                    instr_done_s = 1'b1;
                    state_next_s = S_FETCH;
                end else begin
                    instr_done_s = 1'b0;
                    state_next_s = S_MEMWR;
                end
            end
            S_EXEC: begin
                alusrca_s    = 1'b1;
                alucontrol_s = exec_alu_r;
                state_next_s = S_ALUWB;
            end
            S_ALUWB: begin
                regdst_s     = 1'b1;
                regwrite_s   = 1'b1;
                instr_done_s = 1'b1;
                state_next_s = S_FETCH;
            end
            S_BRANCH: begin
                alusrca_s    = 1'b1;
                alucontrol_s = ALU_SUB;
                pcsrc_s      = 2'b01;
                pcwrite_s    = branch_take_s;
                instr_done_s = 1'b1;
                state_next_s = S_FETCH;
            end
            S_ADDIEX: begin
                alusrca_s    = 1'b1;
                alusrcb_s    = 2'b10;
                state_next_s = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite_s   = 1'b1;
                instr_done_s = 1'b1;
                state_next_s = S_FETCH;
            end
            S_JUMP: begin
                pcsrc_s      = 2'b10;
                pcwrite_s    = 1'b1;
                instr_done_s = 1'b1;
                state_next_s = S_FETCH;
            end
            S_ILLEGAL: begin
                // PC was already advanced in FETCH, so the instruction is skipped.
                illegal_op_s = 1'b1;
                instr_done_s = 1'b1;
                state_next_s = S_FETCH;
            end
            default: begin
                state_next_s = S_FETCH;
            end
        endcase
    end

    // Strobes are forced low while reset is held, independent of mem_ready/zero.
    assign pcwrite    = pcwrite_s    & reset_n;
    assign irwrite    = irwrite_s    & reset_n;
    assign memwrite   = memwrite_s   & reset_n;
    assign regwrite   = regwrite_s   & reset_n;
    assign illegal_op = illegal_op_s & reset_n;
    assign instr_done = instr_done_s & reset_n;

    assign iord       = iord_s;
    assign regdst     = regdst_s;
    assign memtoreg   = memtoreg_s;
    assign alusrca    = alusrca_s;
    assign alusrcb    = alusrcb_s;
    assign pcsrc      = pcsrc_s;
    assign alucontrol = alucontrol_s;
    assign state      = state_r;

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Parametrised multicycle successor to the single-cycle controller. A Moore FSM sequences each instruction over 3–5 cycles.
- Drives a shared-memory multicycle datapath: PC/IR write enables, ALU source selects, register-file and memory strobes.
- Adds a memory-ready handshake, illegal-instruction detection, a per-instruction completion pulse and an optional BNE instruction.

Parameters:
- OP_W, 4, opcode width (>=4); encodings below are zero-extended to OP_W.
- FUNCT_W, 4, funct width (>=4); encodings zero-extended.
- ALUCTRL_W, 4, alucontrol width (>=4).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- op  in  OP_W  opcode from the IR.
- funct  in  FUNCT_W  function field from the IR.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access completes this cycle.
- pcwrite  out  1  PC load strobe.
- iord  out  1  memory address select: 0=PC, 1=ALUOut.
- irwrite  out  1  IR load strobe.
- memwrite  out  1  memory write request.
- regdst  out  1  destination register select: 1=rd, 0=rt.
- memtoreg  out  1  writeback source: 1=MDR, 0=ALUOut.
- regwrite  out  1  register-file write strobe.
- alusrca  out  1  ALU operand A: 0=PC, 1=A register.
- alusrcb  out  2  ALU operand B: 00=B, 01=const 1, 10=sign-extended imm, 11=branch offset.
- pcsrc  out  2  PC source: 00=ALU result, 01=ALUOut, 10=jump target.
- alucontrol  out  ALUCTRL_W  ALU operation.
- illegal_op  out  1  one-cycle pulse on an undecodable instruction.
- instr_done  out  1  one-cycle pulse in the final cycle of each instruction.
- state  out  4  current state (debug).

Behaviour:
- Opcodes: R=0000, LW=0001, SW=0010, BEQ=0011, ADDI=0100, J=0101; BNE=0110 only with the optional feature.
- R-type funct → alucontrol: ADD 0000→0010, SUB 0001→0110, AND 0010→0000, OR 0011→0001, SLT 0100→0111.
- Unlisted outputs in any state are 0; alucontrol defaults to 0010.
- Reset: reset_n low forces state=FETCH (0) asynchronously. While reset_n is low, all strobes (pcwrite, irwrite, memwrite, regwrite, illegal_op, instr_done) are 0.
- Reset mid-instruction aborts the instruction with no further strobes.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, ILLEGAL=12.
- FETCH: iord=0, alusrca=0, alusrcb=01, add, pcsrc=00.
  - irwrite=pcwrite=mem_ready.
  - Hold while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: alusrca=0, alusrcb=11, add (branch target precompute).
  - LW/SW→MEMADR, R→EXEC, BEQ→BRANCH, ADDI→ADDIEX, J→JUMP.
  - Unknown op→ILLEGAL. R-type with unknown funct→ILLEGAL.
- MEMADR: alusrca=1, alusrcb=10, add. LW→MEMRD, SW→MEMWR.
- MEMRD: iord=1; hold until mem_ready=1, then MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1, instr_done=1; then FETCH.
- MEMWR: iord=1, memwrite=1 held while waiting.
  - When mem_ready=1: instr_done=1, then FETCH.
- EXEC: alusrca=1, alusrcb=00, alucontrol from funct; then ALUWB.
- ALUWB: regdst=1, memtoreg=0, regwrite=1, instr_done=1; then FETCH.
- BRANCH: alusrca=1, alusrcb=00, sub, pcsrc=01, pcwrite=zero, instr_done=1; then FETCH.
- ADDIEX: alusrca=1, alusrcb=10, add; then ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1, instr_done=1; then FETCH.
- JUMP: pcsrc=10, pcwrite=1, instr_done=1; then FETCH.
- ILLEGAL: illegal_op=1, instr_done=1, no write strobes; then FETCH. PC is already advanced, so execution skips the instruction.
- Latency with mem_ready held high: R 4, LW 5, SW 4, ADDI 4, BEQ 3, J 3, illegal 3 cycles.
- Each wait cycle with mem_ready=0 adds one cycle.
- op/funct are sampled only in DECODE and MEMADR. Changes elsewhere are ignored.

Optional Feature:
- Macro: MULTICYCLE_CONTROLLER_BNE_EN.
- Defined: op 0110 decodes to BRANCH with pcwrite=~zero; all other BRANCH outputs are identical to BEQ.
- Undefined: op 0110 goes to ILLEGAL.

Test Plan:
- Reset: hold reset_n=0, then release → state=0; all strobes 0 during reset; irwrite=1 on the first cycle with mem_ready=1.
- R-type: op=0000, funct=0001, mem_ready=1 → states 0,1,6,7; alucontrol=0110 in EXEC; regwrite=1 and regdst=1 in ALUWB; instr_done pulses once.
- LW with stalls: op=0001, mem_ready low for 2 cycles in MEMRD → state stays 3 for 3 cycles; then MEMWB with memtoreg=1, regwrite=1; total 7 cycles.
- Branch: op=0011 with zero=1 → pcwrite=1, pcsrc=01 in BRANCH. Repeat with zero=0 → pcwrite=0. Both complete in 3 cycles.
- Illegal: op=1111, and separately op=0000 with funct=1001 → illegal_op pulses once; no regwrite/memwrite; back at FETCH in 3 cycles. Op 0110 behaves per the macro setting.
- Mid-operation reset: assert reset_n=0 during MEMWR while mem_ready=0 → memwrite drops immediately (asynchronously); state=0.
